// File: rtl/alert_cond.sv
// Piezo alert conditioning: battery-low with hysteresis and an over-speed alert with persistence.
// Define ALERT_BATT_FILT_EN to average every 4 battery samples; undefined, avg_batt tracks each sample.
module alert_cond #(
  parameter logic [11:0] BATT_LOW_TH = 12'h800,
  parameter logic [11:0] BATT_HYST   = 12'h040,
  parameter logic [11:0] OVR_SPD_TH  = 12'd1536,
  parameter int          PERSIST     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        batt_vld,
  input  logic [11:0] batt,
  input  logic        spd_vld,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  output logic [11:0] avg_batt,
  output logic        batt_low,
  output logic        ovr_spd
);

  typedef enum logic {SPD_OK = 1'b0, SPD_OVR = 1'b1} spd_state_t;

  localparam logic [7:0]  PERSIST_CNT = 8'(PERSIST);
  localparam logic [12:0] CLR_TH      = {1'b0, BATT_LOW_TH} + {1'b0, BATT_HYST};

  // ---------------- battery path ----------------
  logic avg_upd;

`ifdef ALERT_BATT_FILT_EN
  logic [13:0] sum;
  logic [1:0]  smp_cnt;
  logic [13:0] sum_nxt;

  assign sum_nxt = sum + {2'b00, batt};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_batt <= 12'hFFF;
      sum      <= '0;
      smp_cnt  <= '0;
      avg_upd  <= 1'b0;
    end else begin
      avg_upd <= 1'b0;
      if (batt_vld) begin
        if (smp_cnt == 2'd3) begin
          avg_batt <= sum_nxt[13:2];
          sum      <= '0;
          smp_cnt  <= '0;
          avg_upd  <= 1'b1;
        end else begin
          sum     <= sum_nxt;
          smp_cnt <= smp_cnt + 2'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      avg_batt <= 12'hFFF;
      avg_upd  <= 1'b0;
    end else begin
      avg_upd <= batt_vld;
      if (batt_vld) avg_batt <= batt;
    end
  end
`endif

  // Evaluated the cycle after avg_batt loads, so it sees the fresh average.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      batt_low <= 1'b0;
    end else if (avg_upd) begin
      if (avg_batt < BATT_LOW_TH)
        batt_low <= 1'b1;
      else if ({1'b0, avg_batt} >= CLR_TH)
        batt_low <= 1'b0;
    end
  end

  // ---------------- speed path ----------------
  logic [12:0] spd_sum;
  logic [12:0] spd_abs;
  logic [11:0] speed;
  logic        over;

  // -4096 negates to itself; read as unsigned it is 4096, giving speed 2048.
  assign spd_sum = {lft_spd[11], lft_spd} + {rght_spd[11], rght_spd};
  assign spd_abs = spd_sum[12] ? (~spd_sum + 13'd1) : spd_sum;
  assign speed   = spd_abs[12:1];
  assign over    = speed > OVR_SPD_TH;

  spd_state_t state, state_nxt;
  logic [7:0] pcnt, pcnt_nxt, pcnt_inc;
  logic       qual;

  assign pcnt_inc = pcnt + 8'd1;

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    qual      = 1'b0;
    if (spd_vld) begin
      qual = (state == SPD_OK) ? over : !over;
      if (qual) begin
        if (pcnt_inc == PERSIST_CNT) begin
          state_nxt = (state == SPD_OK) ? SPD_OVR : SPD_OK;
          pcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt_inc;
        end
      end else begin
        pcnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SPD_OK;
      pcnt    <= '0;
      ovr_spd <= 1'b0;
    end else begin
      state   <= state_nxt;
      pcnt    <= pcnt_nxt;
      ovr_spd <= (state_nxt == SPD_OVR);
    end
  end

endmodule

// File: tb/tb_alert_cond.sv
// Directed bench for alert_cond; expectations adapt to whether ALERT_BATT_FILT_EN is defined.
module tb_alert_cond;

  logic        clk;
  logic        rst_n;
  logic        batt_vld;
  logic [11:0] batt;
  logic        spd_vld;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic [11:0] avg_batt;
  logic        batt_low;
  logic        ovr_spd;

  int checks = 0;
  int errors = 0;

`ifdef ALERT_BATT_FILT_EN
  localparam int NSMP = 4;
`else
  localparam int NSMP = 1;
`endif

  alert_cond dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .batt_vld (batt_vld),
    .batt     (batt),
    .spd_vld  (spd_vld),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .avg_batt (avg_batt),
    .batt_low (batt_low),
    .ovr_spd  (ovr_spd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_batt(input logic [11:0] v);
    batt     = v;
    batt_vld = 1'b1;
    tick();
    batt_vld = 1'b0;
  endtask

  // One full averaging window of a constant value.
  task automatic load_avg(input logic [11:0] v);
    for (int i = 0; i < NSMP; i++) send_batt(v);
  endtask

  task automatic send_spd(input int l, input int r);
    lft_spd  = 12'(l);
    rght_spd = 12'(r);
    spd_vld  = 1'b1;
    tick();
    spd_vld  = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    batt_vld = 1'b0;
    batt     = '0;
    spd_vld  = 1'b0;
    lft_spd  = '0;
    rght_spd = '0;
    tick();
    tick();
    chk("rst_avg", avg_batt, 12'hFFF);
    chk("rst_low", {11'd0, batt_low}, 12'd0);
    chk("rst_ovr", {11'd0, ovr_spd}, 12'd0);
    rst_n = 1'b1;
    tick();

    // battery set
`ifdef ALERT_BATT_FILT_EN
    for (int i = 0; i < 3; i++) send_batt(12'h700);
    chk("partial_avg", avg_batt, 12'hFFF);
    send_batt(12'h700);
`else
    send_batt(12'h700);
`endif
    chk("avg_700", avg_batt, 12'h700);
    chk("low_not_yet", {11'd0, batt_low}, 12'd0);
    tick();
    chk("low_set", {11'd0, batt_low}, 12'd1);
    tick();
    chk("low_hold_idle", {11'd0, batt_low}, 12'd1);

    // hysteresis band
    load_avg(12'h820);
    chk("avg_820", avg_batt, 12'h820);
    tick();
    chk("low_820_hold", {11'd0, batt_low}, 12'd1);
    load_avg(12'h83F);
    tick();
    chk("low_83F_hold", {11'd0, batt_low}, 12'd1);
    load_avg(12'h840);
    chk("low_840_same_edge", {11'd0, batt_low}, 12'd1);
    tick();
    chk("low_840_clear", {11'd0, batt_low}, 12'd0);
    load_avg(12'h800);
    tick();
    chk("low_800_hold0", {11'd0, batt_low}, 12'd0);
    load_avg(12'h7FF);
    chk("avg_7FF", avg_batt, 12'h7FF);
    tick();
    chk("low_7FF_set", {11'd0, batt_low}, 12'd1);

`ifdef ALERT_BATT_FILT_EN
    // mixed samples: (0x700+0x701+0x702+0x703)>>2 = 0x701
    send_batt(12'h700);
    send_batt(12'h701);
    send_batt(12'h702);
    send_batt(12'h703);
    chk("avg_mixed", avg_batt, 12'h701);
    // full-scale: 4*0xFFF>>2 = 0xFFF, clears alert
    load_avg(12'hFFF);
    tick();
    chk("low_fff_clear", {11'd0, batt_low}, 12'd0);
`else
    send_batt(12'h900);
    chk("avg_900", avg_batt, 12'h900);
    tick();
    chk("low_900_clear", {11'd0, batt_low}, 12'd0);
`endif

    // over-speed persistence: 7 over, one under, then 8 over
    for (int i = 0; i < 7; i++) send_spd(1600, 1600);
    chk("ovr_after7", {11'd0, ovr_spd}, 12'd0);
    send_spd(1000, 1000);
    chk("ovr_broken", {11'd0, ovr_spd}, 12'd0);
    for (int i = 0; i < 7; i++) begin
      send_spd(1600, 1600);
      tick();
    end
    chk("ovr_after7_gaps", {11'd0, ovr_spd}, 12'd0);
    send_spd(1600, 1600);
    chk("ovr_set", {11'd0, ovr_spd}, 12'd1);

    // extreme negative speed stays over
    for (int i = 0; i < 8; i++) send_spd(-2048, -2048);
    chk("ovr_neg_extreme", {11'd0, ovr_spd}, 12'd1);

    // recovery: 1537+1536 -> 1536 qualifies, 1537+1537 -> 1537 resets count
    for (int i = 0; i < 7; i++) send_spd(1537, 1536);
    chk("ovr_th_hold", {11'd0, ovr_spd}, 12'd1);
    send_spd(1537, 1537);
    for (int i = 0; i < 7; i++) send_spd(100, -100);
    chk("ovr_rec7", {11'd0, ovr_spd}, 12'd1);
    send_spd(100, -100);
    chk("ovr_cleared", {11'd0, ovr_spd}, 12'd0);

    // reset mid-operation
    load_avg(12'h900);
    tick();
    send_batt(12'h100);
    send_batt(12'h100);
    for (int i = 0; i < 5; i++) send_spd(1600, 1600);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_avg", avg_batt, 12'hFFF);
    chk("mid_rst_low", {11'd0, batt_low}, 12'd0);
    chk("mid_rst_ovr", {11'd0, ovr_spd}, 12'd0);
    rst_n = 1'b1;
    tick();
    send_batt(12'h100);
    send_batt(12'h100);
    for (int i = 0; i < 2; i++) send_spd(1600, 1600);
    tick();
`ifdef ALERT_BATT_FILT_EN
    chk("post_rst_avg", avg_batt, 12'hFFF);
    chk("post_rst_low", {11'd0, batt_low}, 12'd0);
`else
    chk("post_rst_avg", avg_batt, 12'h100);
    chk("post_rst_low", {11'd0, batt_low}, 12'd1);
`endif
    chk("post_rst_ovr2", {11'd0, ovr_spd}, 12'd0);
    for (int i = 0; i < 5; i++) send_spd(1600, 1600);
    chk("post_rst_ovr7", {11'd0, ovr_spd}, 12'd0);
    // 8th sample arrives together with a battery sample
    lft_spd  = 12'd1600;
    rght_spd = 12'd1600;
    spd_vld  = 1'b1;
    batt     = 12'h100;
    batt_vld = 1'b1;
    tick();
    spd_vld  = 1'b0;
    batt_vld = 1'b0;
    chk("post_rst_ovr8", {11'd0, ovr_spd}, 12'd1);
`ifdef ALERT_BATT_FILT_EN
    chk("both_vld_avg", avg_batt, 12'hFFF);
`else
    chk("both_vld_avg", avg_batt, 12'h100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alert_cond.md
ALERT_COND -- requirements
Module: alert_cond

Interface
REQ-001 Parameters SHALL be, one per line:
  BATT_LOW_TH, 12'h800, battery-low set threshold (unsigned counts)
  BATT_HYST, 12'h040, hysteresis added to BATT_LOW_TH for clearing
  OVR_SPD_TH, 12'd1536, over-speed threshold on |average wheel speed|
  PERSIST, 8, consecutive speed samples required to change ovr_spd (range 1..255)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  system clock, all logic on rising edge
  rst_n  input  1  synchronous active-low reset
  batt_vld  input  1  one-cycle pulse, batt valid
  batt  input  12  unsigned battery A2D reading
  spd_vld  input  1  one-cycle pulse, lft_spd/rght_spd valid
  lft_spd  input  12  signed left wheel speed
  rght_spd  input  12  signed right wheel speed
  avg_batt  output  12  filtered battery value
  batt_low  output  1  battery-low alert to piezo driver
  ovr_spd  output  1  over-speed alert to piezo driver

Function
REQ-003 Battery path SHALL accumulate batt into a 14-bit sum with a 2-bit sample counter on each batt_vld.
REQ-004 On the edge sampling the 4th batt_vld, avg_batt SHALL load (sum + batt)>>2, and sum and counter SHALL clear.
REQ-005 batt_low SHALL update exactly one cycle after each avg_batt update, never otherwise.
REQ-006 batt_low SHALL set when avg_batt < BATT_LOW_TH and clear when avg_batt >= BATT_LOW_TH + BATT_HYST (13-bit compare, no wrap); otherwise it SHALL hold.
REQ-007 Speed path SHALL form a 13-bit signed sum lft_spd + rght_spd, take its absolute value, shift right by 1, giving a 12-bit unsigned speed (-2048,-2048 -> 2048).
REQ-008 ovr_spd SHALL be driven by a two-state FSM, SPD_OK and SPD_OVR, with an 8-bit persistence counter.
REQ-009 In SPD_OK, each spd_vld with speed > OVR_SPD_TH SHALL increment the counter; speed <= OVR_SPD_TH SHALL clear it; reaching PERSIST SHALL move to SPD_OVR and clear the counter.
REQ-010 In SPD_OVR, each spd_vld with speed <= OVR_SPD_TH SHALL increment the counter; speed > OVR_SPD_TH SHALL clear it; reaching PERSIST SHALL move to SPD_OK and clear the counter.
REQ-011 ovr_spd SHALL be a registered output, 1 exactly when state is SPD_OVR, asserting on the edge that samples the PERSIST-th qualifying spd_vld.
REQ-012 Cycles without spd_vld SHALL leave the counter and state unchanged.
REQ-013 batt_vld and spd_vld in the same cycle SHALL both be processed; the paths are independent.

Reset
REQ-014 On a clock edge with rst_n low: avg_batt = 12'hFFF, batt_low = 0, ovr_spd = 0, state = SPD_OK, sum, sample counter and persistence counter = 0.
REQ-015 Reset mid-operation SHALL discard partial averages and partial persistence counts; no alert SHALL assert until the full count is re-established.

Configuration
REQ-016 Macro ALERT_BATT_FILT_EN defined: battery 4-sample averaging per REQ-003/004.
REQ-017 Macro ALERT_BATT_FILT_EN undefined: accumulator and sample counter SHALL be removed; avg_batt SHALL load batt on every batt_vld edge, batt_low following one cycle later per REQ-005/006.

Verification
REQ-018 Filter on: four batt_vld with batt = 12'h700, 0x700, 0x700, 0x700 -> avg_batt = 0x700 at 4th edge, batt_low = 1 one cycle later.
REQ-019 Hysteresis: from batt_low = 1, average 0x820 -> batt_low stays 1; average 0x840 -> batt_low = 0 one cycle after update.
REQ-020 Over-speed: 8 spd_vld with lft = rght = 1600 -> ovr_spd = 1 on 8th edge; 7 such samples then one with 1000 -> ovr_spd stays 0.
REQ-021 Recovery and extremes: from SPD_OVR, 8 samples lft = rght = -2048 -> ovr_spd stays 1 (speed 2048); then 8 samples lft = 100, rght = -100 -> ovr_spd = 0.
REQ-022 Reset mid-operation: assert rst_n = 0 after 2 batt samples and 5 over-speed samples -> all outputs at reset values; after release, 2 more of each produce no avg_batt update and no ovr_spd.
REQ-023 Filter off build: single batt_vld with batt = 0x7FF -> avg_batt = 0x7FF same edge, batt_low = 1 next cycle.
